bird_physics: RTL and testbench

- Per-frame vertical motion engine for the player bird.
- Integrates gravity and flap impulses into a signed velocity, then integrates velocity into bird_y.
- Drives the bird_y input of the collision stage directly downstream.
- Holds a three-state flight FSM (READY, FLYING, FALLEN) and reports floor contact to game control.

---
 rtl/bird_physics.sv | 155 +++++++++++++++
 tb/tb_bird_physics.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - per-frame gravity/flap integrator with READY/FLYING/FALLEN flight FSM
// Optional flap cooldown is enabled by defining FLAP_COOLDOWN_EN.
module bird_physics #(
  parameter int HEIGHT          = 10,
  parameter int VEL_W           = 8,
  parameter int Y_START         = 240,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 460,
  parameter int GRAVITY         = 1,
  parameter int FLAP_VEL        = -8,
`ifdef FLAP_COOLDOWN_EN
  parameter int MAX_FALL        = 10,
  parameter int COOLDOWN_FRAMES = 4
`else
  parameter int MAX_FALL        = 10
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              flap,
  input  logic              enable,
  input  logic              restart,
  output logic [HEIGHT-1:0] bird_y,
  output logic [VEL_W-1:0]  velocity,
  output logic              on_floor,
  output logic              flying
);

  localparam int YW = HEIGHT + 2;

  typedef enum logic [1:0] {READY, FLYING, FALLEN} state_t;

  state_t                   state_q, state_d;
  logic [HEIGHT-1:0]        bird_y_q, bird_y_d;
  logic signed [VEL_W-1:0]  velocity_q, velocity_d;
  logic                     on_floor_q, on_floor_d;
  logic                     flying_q, flying_d;
  logic                     flap_pending_q, flap_pending_d;
  logic                     flap_prev_q, flap_prev_d;

  logic                     flap_edge;
  logic                     eligible;
  logic                     pend_eff;
  logic                     tick_proc;
  logic                     apply;
  logic signed [VEL_W:0]    v_inc;
  logic signed [VEL_W-1:0]  v_grav;
  logic signed [VEL_W-1:0]  v_new;
  logic signed [YW-1:0]     y_next;

`ifdef FLAP_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  logic [CW-1:0] cd_q, cd_d;
  assign eligible = (cd_q == '0);
`else
  assign eligible = 1'b1;
`endif

  assign flap_edge = flap & ~flap_prev_q;
  assign pend_eff  = flap_pending_q | (flap_edge & eligible);
  assign tick_proc = frame_tick & enable;

  // Gravity step saturates at MAX_FALL; one extra bit keeps the sum from wrapping.
  assign v_inc  = {velocity_q[VEL_W-1], velocity_q} + (VEL_W+1)'(GRAVITY);
  assign v_grav = (v_inc > MAX_FALL) ? VEL_W'(MAX_FALL) : v_inc[VEL_W-1:0];
  assign v_new  = pend_eff ? VEL_W'(FLAP_VEL) : v_grav;
  assign y_next = $signed({2'b00, bird_y_q}) + YW'(v_new);

  always_comb begin
    state_d        = state_q;
    bird_y_d       = bird_y_q;
    velocity_d     = velocity_q;
    flap_prev_d    = flap;
    flap_pending_d = tick_proc ? 1'b0 : pend_eff;
    apply          = 1'b0;

    case (state_q)
      READY:   apply = tick_proc & pend_eff;
      FLYING:  apply = tick_proc;
      default: apply = 1'b0;
    endcase

    if (apply) begin
      state_d = FLYING;
      if (y_next <= Y_MIN) begin
        bird_y_d   = HEIGHT'(Y_MIN);
        velocity_d = '0;
      end else if (y_next >= Y_MAX) begin
        bird_y_d   = HEIGHT'(Y_MAX);
        velocity_d = '0;
        state_d    = FALLEN;
      end else begin
        bird_y_d   = y_next[HEIGHT-1:0];
        velocity_d = v_new;
      end
    end

`ifdef FLAP_COOLDOWN_EN
    cd_d = cd_q;
    if (apply && pend_eff) begin
      cd_d = CW'(COOLDOWN_FRAMES);
    end else if (tick_proc && cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end
`endif

    // Restart wins over everything, including a coincident tick.
    if (restart) begin
      state_d        = READY;
      bird_y_d       = HEIGHT'(Y_START);
      velocity_d     = '0;
      flap_pending_d = 1'b0;
      flap_prev_d    = 1'b0;
`ifdef FLAP_COOLDOWN_EN
      cd_d           = '0;
`endif
    end

    on_floor_d = (state_d == FALLEN);
    flying_d   = (state_d == FLYING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= READY;
      bird_y_q       <= HEIGHT'(Y_START);
      velocity_q     <= '0;
      on_floor_q     <= 1'b0;
      flying_q       <= 1'b0;
      flap_pending_q <= 1'b0;
      flap_prev_q    <= 1'b0;
`ifdef FLAP_COOLDOWN_EN
      cd_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      velocity_q     <= velocity_d;
      on_floor_q     <= on_floor_d;
      flying_q       <= flying_d;
      flap_pending_q <= flap_pending_d;
      flap_prev_q    <= flap_prev_d;
`ifdef FLAP_COOLDOWN_EN
      cd_q           <= cd_d;
`endif
    end
  end

  assign bird_y   = bird_y_q;
  assign velocity = velocity_q;
  assign on_floor = on_floor_q;
  assign flying   = flying_q;

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - scoreboard bench for bird_physics
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       flap;
  logic       enable;
  logic       restart;
  logic [9:0] bird_y;
  logic [7:0] velocity;
  logic       on_floor;
  logic       flying;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int y;
    int v;
    int fl;
    int of;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: st 0=READY 1=FLYING 2=FALLEN
  int m_y, m_v, m_st, m_cd;
  bit m_pend, m_prev;

  bird_physics dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .flap       (flap),
    .enable     (enable),
    .restart    (restart),
    .bird_y     (bird_y),
    .velocity   (velocity),
    .on_floor   (on_floor),
    .flying     (flying)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sv(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_y = 240; m_v = 0; m_st = 0; m_cd = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit f, input bit tk, input bit en, input bit rs);
    bit edge_s, elig, pe, proc, applied;
    int nv, ny;
    if (rs) begin
      model_reset();
      return;
    end
    edge_s = f && !m_prev;
`ifdef FLAP_COOLDOWN_EN
    elig = (m_cd == 0);
`else
    elig = 1'b1;
`endif
    pe = m_pend || (edge_s && elig);
    proc = tk && en;
    applied = 0;
    if (proc && (m_st == 1 || (m_st == 0 && pe))) begin
      nv = pe ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
      ny = m_y + nv;
      m_st = 1;
      applied = pe;
      if (ny <= 0) begin
        m_y = 0; m_v = 0;
      end else if (ny >= 460) begin
        m_y = 460; m_v = 0; m_st = 2;
      end else begin
        m_y = ny; m_v = nv;
      end
    end
    if (applied) m_cd = 4;
    else if (proc && m_cd > 0) m_cd--;
    m_pend = proc ? 1'b0 : pe;
    m_prev = f;
  endtask

  // One clock: drive on negedge, push expectation, compare 1 time unit after posedge.
  task automatic cyc(input bit f, input bit tk, input bit en, input bit rs);
    exp_t e;
    @(negedge clk);
    flap = f; frame_tick = tk; enable = en; restart = rs;
    model_step(f, tk, en, rs);
    e.y = m_y; e.v = m_v; e.fl = (m_st == 1) ? 1 : 0; e.of = (m_st == 2) ? 1 : 0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_bird_y", int'(bird_y), e.y);
      chk("sb_velocity", sv(velocity), e.v);
      chk("sb_flying", int'(flying), e.fl);
      chk("sb_on_floor", int'(on_floor), e.of);
    end
  endtask

  task automatic flap_tick();
    cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
  endtask

  task automatic plain_tick();
    cyc(0, 1, 1, 0);
  endtask

  initial begin
    int n;
    flap = 0; frame_tick = 0; enable = 1; restart = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bird_y", int'(bird_y), 240);
    chk("rst_velocity", sv(velocity), 0);
    chk("rst_flying", int'(flying), 0);
    chk("rst_on_floor", int'(on_floor), 0);
    @(negedge clk);
    reset = 1;

    repeat (5) plain_tick();
    chk("ready_hold_y", int'(bird_y), 240);
    chk("ready_hold_fl", int'(flying), 0);

    flap_tick();
    chk("first_flap_fl", int'(flying), 1);
    chk("first_flap_v", sv(velocity), -8);
    chk("first_flap_y", int'(bird_y), 232);
    plain_tick();
    chk("grav_v", sv(velocity), -7);
    chk("grav_y", int'(bird_y), 225);

    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("frozen_y", int'(bird_y), 225);
    chk("frozen_v", sv(velocity), -7);
    plain_tick();
`ifndef FLAP_COOLDOWN_EN
    chk("unfreeze_v", sv(velocity), -8);
    chk("unfreeze_y", int'(bird_y), 217);
`endif

    n = 0;
    while (!on_floor && n < 60) begin
      plain_tick();
      chk("fall_vmax", (sv(velocity) > 10) ? 1 : 0, 0);
      n++;
    end
    chk("floor_on", int'(on_floor), 1);
    chk("floor_y", int'(bird_y), 460);
    chk("floor_v", sv(velocity), 0);
    flap_tick();
    plain_tick();
    chk("floor_hold_y", int'(bird_y), 460);

    cyc(0, 1, 1, 1);
    chk("restart_y", int'(bird_y), 240);
    chk("restart_v", sv(velocity), 0);
    chk("restart_floor", int'(on_floor), 0);
    chk("restart_fl", int'(flying), 0);

`ifndef FLAP_COOLDOWN_EN
    repeat (30) flap_tick();
    chk("ceil30_y", int'(bird_y), 0);
    flap_tick();
    chk("ceil31_y", int'(bird_y), 0);
    chk("ceil31_v", sv(velocity), 0);
`else
    flap_tick();
    chk("cd_v1", sv(velocity), -8);
    flap_tick();
    chk("cd_v2", sv(velocity), -7);
    flap_tick();
    chk("cd_v3", sv(velocity), -6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
